// File: rtl/ctrl_pipe.sv
// Pipeline control for a 5-stage MIPS-style core: hazard stall, branch/jump redirect,
// EX/MEM/WB control registers and operand forwarding (forwarding enabled by CTRL_PIPE_FWD_EN).
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_alu_src,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_j,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush_if,
  output logic [1:0]       pc_src,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_write,
  output logic             mem_read,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dst
);

  localparam logic [REG_W-1:0] R0 = {REG_W{1'b0}};

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic             beq;
    logic             bne;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic [REG_W-1:0] dst;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] dst;
  } wb_t;

  ex_t  ex_q,  ex_d;
  mem_t mem_q, mem_d;
  wb_t  wb_q,  wb_d;

  logic [REG_W-1:0] id_dst;
  logic             id_rw;
  logic             id_rt_used;
  logic             load_use;
  logic             hazard;
  logic             taken;
  logic             jump;

  // A producer in a later stage conflicts when it writes a nonzero register read by ID.
  function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             rt_used);
    return (dst != R0) && ((dst == rs) || (rt_used && (dst == rt)));
  endfunction

  assign id_dst     = id_reg_dst ? id_rd : id_rt;
  assign id_rw      = id_reg_write & (id_dst != R0);
  assign id_rt_used = ~id_alu_src | id_mem_write;

  assign load_use = id_valid & ex_q.valid & ex_q.mem_to_reg &
                    src_hit(ex_q.dst, id_rs, id_rt, id_rt_used);

`ifdef CTRL_PIPE_FWD_EN
  assign hazard = load_use;
`else
  assign hazard = load_use |
                  (id_valid & ex_q.valid & ex_q.reg_write &
                   src_hit(ex_q.dst, id_rs, id_rt, id_rt_used)) |
                  (id_valid & mem_q.valid & mem_q.reg_write &
                   src_hit(mem_q.dst, id_rs, id_rt, id_rt_used));
`endif

  assign taken = ex_q.valid & ((ex_q.beq & ex_zero) | (ex_q.bne & ~ex_zero));
  assign jump  = id_valid & id_j & ~taken & ~hazard;

  // Redirect and hold; reset suppresses every request.
  always_comb begin
    stall    = 1'b0;
    flush_if = 1'b0;
    pc_src   = 2'b00;
    if (rst) begin
      stall    = 1'b0;
    end else if (taken) begin
      flush_if = 1'b1;
      pc_src   = 2'b01;
    end else if (hazard) begin
      stall    = 1'b1;
    end else if (jump) begin
      flush_if = 1'b1;
      pc_src   = 2'b10;
    end else begin
      pc_src   = 2'b00;
    end
  end

  // Stage advance; a squashed or stalled ID becomes a bubble in EX.
  always_comb begin
    ex_d = {$bits(ex_t){1'b0}};
    if (taken || hazard || !id_valid) begin
      ex_d = {$bits(ex_t){1'b0}};
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.reg_write  = id_rw & ~id_j;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.mem_write  = id_mem_write;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_dst    = id_reg_dst;
      ex_d.beq        = id_beq;
      ex_d.bne        = id_bne;
      ex_d.dst        = id_dst;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
    end
    mem_d.valid      = ex_q.valid;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.dst        = ex_q.dst;
    wb_d.valid       = mem_q.valid;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.dst         = mem_q.dst;
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= {$bits(ex_t){1'b0}};
      mem_q <= {$bits(mem_t){1'b0}};
      wb_q  <= {$bits(wb_t){1'b0}};
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  // MEM result is younger than WB, so it takes priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_q.valid && mem_q.reg_write && (mem_q.dst == ex_q.rs) && (ex_q.rs != R0)) begin
      fwd_a = 2'b10;
    end else if (wb_q.valid && wb_q.reg_write && (wb_q.dst == ex_q.rs) && (ex_q.rs != R0)) begin
      fwd_a = 2'b01;
    end else begin
      fwd_a = 2'b00;
    end
    if (mem_q.valid && mem_q.reg_write && (mem_q.dst == ex_q.rt) && (ex_q.rt != R0)) begin
      fwd_b = 2'b10;
    end else if (wb_q.valid && wb_q.reg_write && (wb_q.dst == ex_q.rt) && (ex_q.rt != R0)) begin
      fwd_b = 2'b01;
    end else begin
      fwd_b = 2'b00;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign mem_write     = mem_q.valid & mem_q.mem_write;
  assign mem_read      = mem_q.valid & mem_q.mem_to_reg;
  assign wb_reg_write  = wb_q.valid & wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.valid & wb_q.mem_to_reg;
  assign wb_dst        = wb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed-vector bench for ctrl_pipe; expectations follow CTRL_PIPE_FWD_EN when defined.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg;
  logic       id_beq, id_bne, id_j;
  logic       ex_zero;
  logic       stall, flush_if;
  logic [1:0] pc_src;
  logic       ex_alu_src, ex_reg_dst;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_write, mem_read, wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dst;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_pipe #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j), .ex_zero(ex_zero),
    .stall(stall), .flush_if(flush_if), .pc_src(pc_src),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_write(mem_write), .mem_read(mem_read),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one ID instruction, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rdst, input logic rw,
                       input logic asrc, input logic mw, input logic m2r,
                       input logic beq, input logic bne, input logic j);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_dst = rdst; id_reg_write = rw; id_alu_src = asrc;
    id_mem_write = mw; id_mem_to_reg = m2r;
    id_beq = beq; id_bne = bne; id_j = j;
    #1;
  endtask

  task automatic nop();                    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0); endtask
  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, rs, rt, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0);
  endtask
  task automatic sw(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, rs, rt, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0);
  endtask
  task automatic add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, rs, rt, rd, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
  endtask
  task automatic br(input logic beq, input logic bne);
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, beq,bne,1'b0);
  endtask
  task automatic drain();
    repeat (4) begin cyc(); nop(); end
  endtask

  initial begin
    rst = 1'b1; ex_zero = 1'b0;
    nop();
    cyc(); cyc();
    // Reset state, with a jump in ID that must be suppressed
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("rst_pc_src", {6'd0, pc_src}, 8'h00);
    check_eq("rst_flush", {7'd0, flush_if}, 8'h00);
    check_eq("rst_wb_rw", {7'd0, wb_reg_write}, 8'h00);
    check_eq("rst_fwd", {4'd0, fwd_a, fwd_b}, 8'h00);
    rst = 1'b0;
    nop();
    drain();

    // lw $2 ; add $3,$2,$4
    lw(5'd1, 5'd2);
    check_eq("lu_t0_stall", {7'd0, stall}, 8'h00);
    cyc(); add(5'd3, 5'd2, 5'd4);
    check_eq("lu_t1_stall", {7'd0, stall}, 8'h01);
    check_eq("lu_t1_ex_alu_src", {7'd0, ex_alu_src}, 8'h01);
    check_eq("lu_t1_flush", {7'd0, flush_if}, 8'h00);
    cyc(); add(5'd3, 5'd2, 5'd4);
    check_eq("lu_t2_bubble", {6'd0, ex_alu_src, ex_reg_dst}, 8'h00);
    check_eq("lu_t2_mem_read", {7'd0, mem_read}, 8'h01);
`ifdef CTRL_PIPE_FWD_EN
    check_eq("lu_t2_stall", {7'd0, stall}, 8'h00);
    cyc(); nop();
    check_eq("lu_t3_fwd_a", {6'd0, fwd_a}, 8'h01);
    check_eq("lu_t3_ex_reg_dst", {7'd0, ex_reg_dst}, 8'h01);
`else
    check_eq("lu_t2_stall", {7'd0, stall}, 8'h01);
    cyc(); add(5'd3, 5'd2, 5'd4);
    check_eq("lu_t3_bubble", {7'd0, ex_reg_dst}, 8'h00);
`endif
    check_eq("lu_t3_stall", {7'd0, stall}, 8'h00);
    check_eq("lu_t3_wb", {wb_reg_write, wb_mem_to_reg, 1'b0, wb_dst}, 8'hC2);
`ifndef CTRL_PIPE_FWD_EN
    cyc(); nop();
    check_eq("lu_t4_ex_reg_dst", {7'd0, ex_reg_dst}, 8'h01);
    check_eq("lu_t4_fwd_a", {6'd0, fwd_a}, 8'h00);
`endif
    drain();

    // add $2,$1,$1 ; sub $5,$2,$2
    add(5'd2, 5'd1, 5'd1);
    cyc(); add(5'd5, 5'd2, 5'd2);
`ifdef CTRL_PIPE_FWD_EN
    check_eq("raw_t1_stall", {7'd0, stall}, 8'h00);
    cyc(); nop();
    check_eq("raw_t2_fwd", {4'd0, fwd_a, fwd_b}, 8'h0A);
`else
    check_eq("raw_t1_stall", {7'd0, stall}, 8'h01);
    cyc(); add(5'd5, 5'd2, 5'd2);
    check_eq("raw_t2_stall", {7'd0, stall}, 8'h01);
    cyc(); add(5'd5, 5'd2, 5'd2);
    check_eq("raw_t3_stall", {7'd0, stall}, 8'h00);
    cyc(); nop();
    check_eq("raw_t4_fwd", {4'd0, fwd_a, fwd_b}, 8'h00);
`endif
    check_eq("raw_ex_reg_dst", {7'd0, ex_reg_dst}, 8'h01);
    drain();

    // beq taken, then not taken, then bne taken
    br(1'b1, 1'b0);
    check_eq("beq_idle_pc", {6'd0, pc_src}, 8'h00);
    cyc(); ex_zero = 1'b1; add(5'd7, 5'd1, 5'd1);
    check_eq("beq_tk_redirect", {5'd0, stall, flush_if, pc_src[0]}, 8'h03);
    check_eq("beq_tk_pc_src", {6'd0, pc_src}, 8'h01);
    cyc(); ex_zero = 1'b0; br(1'b1, 1'b0);
    check_eq("beq_tk_squash", {7'd0, ex_reg_dst}, 8'h00);
    check_eq("beq_tk_after_pc", {6'd0, pc_src}, 8'h00);
    cyc(); add(5'd7, 5'd1, 5'd1);
    check_eq("beq_nt_redirect", {5'd0, flush_if, pc_src}, 8'h00);
    cyc(); br(1'b0, 1'b1);
    check_eq("beq_nt_pass", {7'd0, ex_reg_dst}, 8'h01);
    cyc(); nop();
    check_eq("bne_tk_pc_src", {5'd0, flush_if, pc_src}, 8'h05);
    drain();

    // Branch-load in EX with a dependent in ID: branch wins, no stall
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0);
    cyc(); ex_zero = 1'b1; add(5'd3, 5'd2, 5'd4);
    check_eq("tk_lu_ctl", {4'd0, stall, flush_if, pc_src}, 8'h05);
    cyc(); ex_zero = 1'b0; nop();
    check_eq("tk_lu_squash", {7'd0, ex_reg_dst}, 8'h00);
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0);
    cyc(); add(5'd3, 5'd2, 5'd4);
    check_eq("nt_lu_ctl", {4'd0, stall, flush_if, pc_src}, 8'h08);
    drain();

    // Jump with reg_write set must not write back
    drive(1'b1, 5'd0, 5'd0, 5'd31, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("j_ctl", {4'd0, stall, flush_if, pc_src}, 8'h06);
    cyc(); nop(); cyc(); nop(); cyc(); nop();
    check_eq("j_wb_rw", {7'd0, wb_reg_write}, 8'h00);
    drain();

    // Jump deferred behind a load-use stall
    lw(5'd1, 5'd2);
    cyc(); drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("jd_t1_ctl", {4'd0, stall, flush_if, pc_src}, 8'h08);
`ifndef CTRL_PIPE_FWD_EN
    cyc(); drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("jd_t2_ctl", {4'd0, stall, flush_if, pc_src}, 8'h08);
`endif
    cyc(); drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("jd_rel_ctl", {4'd0, stall, flush_if, pc_src}, 8'h06);
    drain();

    // Writes to $0 are not producers
    add(5'd0, 5'd1, 5'd1);
    cyc(); add(5'd3, 5'd0, 5'd0);
    check_eq("r0_stall", {7'd0, stall}, 8'h00);
    cyc(); nop();
    check_eq("r0_fwd", {4'd0, fwd_a, fwd_b}, 8'h00);
    cyc(); nop();
    check_eq("r0_wb_rw", {7'd0, wb_reg_write}, 8'h00);
    drain();

    // Reset mid-stream with sw in MEM and add $9 in WB
    add(5'd9, 5'd1, 5'd1);
    cyc(); sw(5'd1, 5'd2);
    cyc(); nop();
    cyc(); nop();
    check_eq("ms_mem_write", {7'd0, mem_write}, 8'h01);
    check_eq("ms_wb", {wb_reg_write, 2'd0, wb_dst}, 8'h89);
    rst = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1);
    check_eq("ms_rst_ctl", {4'd0, stall, flush_if, pc_src}, 8'h00);
    cyc(); nop();
    check_eq("ms_mem", {6'd0, mem_write, mem_read}, 8'h00);
    check_eq("ms_wb_clr", {wb_reg_write, wb_mem_to_reg, 1'b0, wb_dst}, 8'h00);
    check_eq("ms_ex_clr", {6'd0, ex_alu_src, ex_reg_dst}, 8'h00);
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
